// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: shared display constants, FSM states, shadow layout and hex-to-segment table
package seg7_scan_driver_pkg;

    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {ST_OFF, ST_SCAN} state_e;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } shadow_t;

    // Active-low segment patterns, entry 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][6:0] HEX2SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational 4-bit hex to active-low 7-segment pattern, seg_o[0]=a ... seg_o[6]=g
module seg7_hex_decoder
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX2SEG[hex_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-seg scanner with per-frame shadowing and optional blink (macro SEG7_SCAN_BLINK_GEN_EN)
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLINK_DIV   = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        blink,
    output logic        frame_start
);

    localparam int RW = $clog2(REFRESH_DIV);

    if (REFRESH_DIV < 2 || BLINK_DIV < 2) begin : g_bad_div
        $error("seg7_scan_driver: REFRESH_DIV and BLINK_DIV must be >= 2");
    end

    state_e          st_q;
    logic [RW-1:0]   refresh_cnt_q;
    logic [1:0]      idx_q;
    shadow_t         shadow_q;
    shadow_t         shadow_d;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;
    logic            fs_q;
    logic [3:0]      hex_d;
    logic [6:0]      dec_seg;
    logic [6:0]      seg_d;
    logic [3:0]      an_d;
    logic            dp_d;
    logic            wrap;

    assign shadow_d = {digits, dp_mask, blank_mask};
    assign hex_d    = shadow_q.digits[{idx_q, 2'b00} +: 4];
    assign seg_d    = shadow_q.blank[idx_q] ? SEG_BLANK : dec_seg;
    assign an_d     = ~(4'b0001 << idx_q);
    assign dp_d     = ~shadow_q.dp[idx_q];
    assign wrap     = refresh_cnt_q == RW'(REFRESH_DIV - 1);

    seg7_hex_decoder u_dec (
        .hex_i (hex_d),
        .seg_o (dec_seg)
    );

    // Scan FSM: shadow load at frame boundaries, digit index stepping and registered pin drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q          <= ST_OFF;
            refresh_cnt_q <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            fs_q          <= 1'b0;
        end else if (st_q == ST_OFF || !en) begin
            refresh_cnt_q <= '0;
            idx_q         <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            fs_q          <= 1'b0;
            st_q          <= ST_OFF;
            if (st_q == ST_OFF && en) begin
                st_q     <= ST_SCAN;
                shadow_q <= shadow_d;
                fs_q     <= 1'b1;
            end
        end else begin
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            fs_q          <= 1'b0;
            refresh_cnt_q <= wrap ? '0 : refresh_cnt_q + RW'(1);
            if (wrap) begin
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    shadow_q <= shadow_d;
                    fs_q     <= 1'b1;
                end
            end
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

`ifdef SEG7_SCAN_BLINK_GEN_EN
    localparam int BW = $clog2(BLINK_DIV);

    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;

    // Blink half-period counter; runs only while scanning, held at visible otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (st_q == ST_SCAN && en) begin
            blink_cnt_q <= (blink_cnt_q == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + BW'(1);
            blink_q     <= (blink_cnt_q == BW'(BLINK_DIV - 1)) ? ~blink_q : blink_q;
        end else begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed vector bench for seg7_scan_driver with REFRESH_DIV=4, BLINK_DIV=8
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        blink;
    logic        frame_start;
    logic [3:0]  exp_an;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0]      digits;
        logic [3:0]       dp_mask;
        logic [3:0]       blank_mask;
        logic [3:0][6:0]  seg;
        logic [3:0]       dp;
    } vec_t;

    vec_t vecs [4];

    seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .blink       (blink),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic chk_dark(string name);
        chk({name, " an"}, an, 4'b1111);
        chk({name, " seg"}, seg, 7'h7F);
        chk({name, " dp"}, dp, 1'b1);
    endtask

    task automatic wait_fs(string name);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({name, " frame_start seen"}, frame_start, 1'b1);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'hABCD, 4'b0000, 4'b0000, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
        vecs[2] = '{16'h5678, 4'b0101, 4'b0010, {7'h12, 7'h02, 7'h7F, 7'h00}, 4'b1010};
        vecs[3] = '{16'h9EF0, 4'b1111, 4'b1001, {7'h7F, 7'h06, 7'h0E, 7'h7F}, 4'b0000};

        // reset state and dark while disabled
        tick(2);
        chk_dark("reset");
        chk("reset blink", blink, 1'b1);
        chk("reset fs", frame_start, 1'b0);
        rst_n = 1'b1;
        tick(5);
        chk_dark("idle");
        chk("idle fs", frame_start, 1'b0);

        // one full frame per vector
        en = 1'b1;
        for (int v = 0; v < 4; v++) begin
            digits     = vecs[v].digits;
            dp_mask    = vecs[v].dp_mask;
            blank_mask = vecs[v].blank_mask;
            wait_fs($sformatf("v%0d", v));
            tick();
            chk($sformatf("v%0d fs single", v), frame_start, 1'b0);
            tick();
            for (int i = 0; i < 4; i++) begin
                exp_an = ~(4'b0001 << i);
                chk($sformatf("v%0d an d%0d", v, i), an, exp_an);
                chk($sformatf("v%0d seg d%0d", v, i), seg, vecs[v].seg[i]);
                chk($sformatf("v%0d dp d%0d", v, i), dp, vecs[v].dp[i]);
                tick(4);
            end
        end

        // digits change mid-frame must not tear the current frame
        digits = 16'h1234; dp_mask = '0; blank_mask = '0;
        wait_fs("tear");
        tick(10);
        digits = 16'hABCD;
        chk("tear d2 an", an, 4'b1011);
        chk("tear d2 old", seg, 7'h24);
        tick(4);
        chk("tear d3 old", seg, 7'h79);
        wait_fs("tear next");
        tick(2);
        chk("tear next an", an, 4'b1110);
        chk("tear next d0", seg, 7'h21);

        // frame_start period is 16 clocks
        tick(14);
        chk("fs period", frame_start, 1'b1);

        // en dropped while digit 1 is lit, then restart
        tick(6);
        chk("drop pre an", an, 4'b1101);
        en = 1'b0;
        tick();
        chk_dark("drop");
        tick(3);
        chk_dark("drop hold");
        en = 1'b1;
        tick();
        chk("restart fs", frame_start, 1'b1);
        chk("restart an dark", an, 4'b1111);
        tick();
        chk("restart fs low", frame_start, 1'b0);
        chk("restart an d0", an, 4'b1110);
        chk("restart seg d0", seg, 7'h21);

        // asynchronous reset mid-scan acts without a clock edge
        tick(3);
        rst_n = 1'b0;
        #1;
        chk_dark("async rst");
        chk("async rst blink", blink, 1'b1);
        chk("async rst fs", frame_start, 1'b0);
        tick(2);
        rst_n = 1'b1;
        en = 1'b0;
        tick(3);
        chk_dark("post rst");

        // blink strobe
        en = 1'b1;
        tick();
        chk("blink entry fs", frame_start, 1'b1);
`ifdef SEG7_SCAN_BLINK_GEN_EN
        chk("blink entry", blink, 1'b1);
        tick(7);
        chk("blink e7", blink, 1'b1);
        tick();
        chk("blink e8", blink, 1'b0);
        tick(7);
        chk("blink e15", blink, 1'b0);
        tick();
        chk("blink e16", blink, 1'b1);
        tick(8);
        chk("blink e24", blink, 1'b0);
        en = 1'b0;
        tick();
        chk("blink off", blink, 1'b1);
`else
        for (int c = 0; c < 100; c++) begin
            chk($sformatf("blink const c%0d", c), blink, 1'b1);
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
